// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and counter sizing for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNT_MIN_W = 1;

   function automatic int cnt_width(input int w);
      return ($clog2(w) > CNT_MIN_W) ? $clog2(w) : CNT_MIN_W;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// fa_cell: combinational 1-bit full adder from two half-adder stages and an OR for carry.
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic p, g0, g1;

   assign p    = a ^ b;
   assign g0   = a & b;
   assign sum  = p ^ cin;
   assign g1   = p & cin;
   assign cout = g0 | g1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add sequencer, LSB first, over one shared fa_cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output logic             busy
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr, b_sr, acc_sr, acc_nxt;
   logic [WIDTH:0]   acc_cat;
   logic [CW-1:0]    cnt;
   logic             carry, s_bit, c_bit, last;

   fa_cell u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .sum  (s_bit),
      .cout (c_bit)
   );

   // new sum bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts
   assign acc_cat   = {s_bit, acc_sr};
   assign acc_nxt   = acc_cat[WIDTH:1];
   assign last      = cnt == CW'(WIDTH - 1);
   assign in_ready  = state_q == IDLE;
   assign busy      = state_q == RUN;
   assign out_valid = state_q == DONE;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_valid  ? RUN  : IDLE;
         RUN:     state_d = last      ? DONE : RUN;
         DONE:    state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         acc_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
      end else if (state_q == IDLE && in_valid) begin
         a_sr  <= a;
         b_sr  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state_q == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         acc_sr <= acc_nxt;
         carry  <= c_bit;
         cnt    <= cnt + CW'(1);
      end

   // on the final bit, carry is the carry into the MSB and c_bit the carry out of it
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sum  <= '0;
         cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf  <= 1'b0;
`endif
      end else if (state_q == RUN && last) begin
         sum  <= acc_nxt;
         cout <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
         ovf  <= carry ^ c_bit;
`endif
      end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=8).
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] sum;
   logic       cout;
   logic       busy;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif
   logic       fa_a, fa_b, fa_c, fa_s, fa_co;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .busy      (busy)
   );

   fa_cell u_fa (.a(fa_a), .b(fa_b), .cin(fa_c), .sum(fa_s), .cout(fa_co));

   // drive at negedge; the following posedge is the accepting edge
   task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic tc);
      in_valid = 1'b1;
      a = ta;
      b = tb_;
      cin = tc;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1) begin
         nerr++;
         $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
      end
   endtask

   task automatic consume;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      nvec++;
      if ({in_ready, out_valid, busy, sum, cout} !== {1'b1, 1'b0, 1'b0, 8'h00, 1'b0}) begin
         nerr++;
         $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b required 1 0 0 00 0",
                  in_ready, out_valid, busy, sum, cout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fa_cell;
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         logic [1:0] exp;
         v = 3'(i);
         {fa_a, fa_b, fa_c} = v;
         exp = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
         #1;
         nvec++;
         if ({fa_co, fa_s} !== exp) begin
            nerr++;
            $display("FAIL fa_cell in=%b: got %b required %b", v, {fa_co, fa_s}, exp);
         end
      end
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      issue(8'h5A, 8'h3C, 1'b0);
      repeat (7) @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin
         nerr++;
         $display("FAIL latency early: out_valid=%b required 0", out_valid);
      end
      @(negedge clk);
      nvec++;
      if ({out_valid, sum, cout} !== {1'b1, 8'h96, 1'b0}) begin
         nerr++;
         $display("FAIL basic 5A+3C: vld=%b sum=%h cout=%b required 1 96 0", out_valid, sum, cout);
      end
      @(negedge clk);
      out_ready = 1'b0;
      nvec++;
      if ({in_ready, out_valid} !== 2'b10) begin
         nerr++;
         $display("FAIL basic return idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_carry;
      issue(8'hFF, 8'h00, 1'b1);
      wait_done("carry_ff_00_1");
      nvec++;
      if ({cout, sum} !== 9'h100) begin
         nerr++;
         $display("FAIL carry FF+00+1: got %h required 100", {cout, sum});
      end
      consume();
      issue(8'hFF, 8'h01, 1'b0);
      wait_done("carry_ff_01_0");
      nvec++;
      if ({cout, sum} !== 9'h100) begin
         nerr++;
         $display("FAIL carry FF+01+0: got %h required 100", {cout, sum});
      end
      consume();
   endtask

   task automatic test_backpressure;
      issue(8'hC3, 8'h5B, 1'b1);
      wait_done("bp");
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if ({out_valid, in_ready, cout, sum} !== {1'b1, 1'b0, 9'h11F}) begin
            nerr++;
            $display("FAIL backpressure cyc%0d: vld=%b rdy=%b res=%h required 1 0 11f",
                     i, out_valid, in_ready, {cout, sum});
         end
         @(negedge clk);
      end
      consume();
      nvec++;
      if ({in_ready, out_valid, cout, sum} !== {1'b1, 1'b0, 9'h11F}) begin
         nerr++;
         $display("FAIL bp release: rdy=%b vld=%b res=%h required 1 0 11f",
                  in_ready, out_valid, {cout, sum});
      end
   endtask

   task automatic test_busy_ignore;
      issue(8'h11, 8'h22, 1'b0);
      in_valid = 1'b1;
      a = 8'hAA;
      b = 8'h55;
      cin = 1'b1;
      @(negedge clk);
      nvec++;
      if ({busy, in_ready} !== 2'b10) begin
         nerr++;
         $display("FAIL busy flags: busy=%b rdy=%b required 1 0", busy, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_done("busy_ignore");
      nvec++;
      if ({cout, sum} !== 9'h033) begin
         nerr++;
         $display("FAIL busy ignore: got %h required 033", {cout, sum});
      end
      // offer new operands together with consuming the result
      in_valid = 1'b1;
      a = 8'h01;
      b = 8'h02;
      cin = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      nvec++;
      if ({in_ready, busy} !== 2'b10) begin
         nerr++;
         $display("FAIL done+valid: rdy=%b busy=%b required 1 0", in_ready, busy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      nvec++;
      if (busy !== 1'b1) begin
         nerr++;
         $display("FAIL accept after idle: busy=%b required 1", busy);
      end
      wait_done("late_accept");
      nvec++;
      if ({cout, sum} !== 9'h003) begin
         nerr++;
         $display("FAIL late accept 01+02: got %h required 003", {cout, sum});
      end
      consume();
   endtask

   task automatic test_mid_reset;
      issue(8'hFF, 8'hFF, 1'b1);
      wait_done("pre_reset");
      consume();
      issue(8'hFF, 8'hFF, 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      nvec++;
      if ({in_ready, busy, out_valid, cout, sum} !== {1'b1, 1'b0, 1'b0, 9'h000}) begin
         nerr++;
         $display("FAIL async reset: rdy=%b busy=%b vld=%b res=%h required 1 0 0 000",
                  in_ready, busy, out_valid, {cout, sum});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(8'h01, 8'h01, 1'b0);
      wait_done("post_reset");
      nvec++;
      if ({cout, sum} !== 9'h002) begin
         nerr++;
         $display("FAIL post reset 01+01: got %h required 002", {cout, sum});
      end
      consume();
   endtask

   task automatic test_back_to_back;
      logic [7:0] va [3] = '{8'h80, 8'h0F, 8'hA5};
      logic [7:0] vb [3] = '{8'h80, 8'hF1, 8'h5A};
      logic       vc [3] = '{1'b0, 1'b0, 1'b1};
      logic [8:0] ve [3] = '{9'h100, 9'h100, 9'h100};
      for (int i = 0; i < 3; i++) begin
         issue(va[i], vb[i], vc[i]);
         wait_done("b2b");
         nvec++;
         if ({cout, sum} !== ve[i]) begin
            nerr++;
            $display("FAIL b2b %0d: got %h required %h", i, {cout, sum}, ve[i]);
         end
         consume();
      end
      issue(8'h12, 8'h34, 1'b1);
      wait_done("b2b_last");
      nvec++;
      if ({cout, sum} !== 9'h047) begin
         nerr++;
         $display("FAIL b2b 12+34+1: got %h required 047", {cout, sum});
      end
      consume();
   endtask

`ifdef SERIAL_ADDER_OVF_EN
   task automatic test_ovf;
      issue(8'h7F, 8'h01, 1'b0);
      wait_done("ovf1");
      nvec++;
      if ({ovf, cout, sum} !== {1'b1, 1'b0, 8'h80}) begin
         nerr++;
         $display("FAIL ovf 7F+01: ovf=%b cout=%b sum=%h required 1 0 80", ovf, cout, sum);
      end
      consume();
      issue(8'h80, 8'h80, 1'b0);
      wait_done("ovf2");
      nvec++;
      if ({ovf, cout, sum} !== {1'b1, 1'b1, 8'h00}) begin
         nerr++;
         $display("FAIL ovf 80+80: ovf=%b cout=%b sum=%h required 1 1 00", ovf, cout, sum);
      end
      consume();
      issue(8'h10, 8'h20, 1'b0);
      wait_done("ovf3");
      nvec++;
      if ({ovf, cout, sum} !== {1'b0, 1'b0, 8'h30}) begin
         nerr++;
         $display("FAIL ovf 10+20: ovf=%b cout=%b sum=%h required 0 0 30", ovf, cout, sum);
      end
      consume();
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_fa_cell();
      test_basic();
      test_carry();
      test_backpressure();
      test_busy_ignore();
      test_mid_reset();
      test_back_to_back();
`ifdef SERIAL_ADDER_OVF_EN
      test_ovf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
